// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
//   Radix-2 shift-add sequential multiplier. One multiplier bit is retired per
//   clock, so every operation takes exactly WIDTH+1 cycles from the accept
//   edge to the done pulse, whatever the operand values. Signed operands are
//   converted to magnitudes on entry, multiplied unsigned, and the sign is
//   applied to the final product.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (highest priority)
//   start        operation request, only looked at while idle
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a_in         multiplicand (sampled with start)
//   b_in         multiplier (sampled with start)
//   busy         high while an operation is in flight
//   done         one-cycle pulse when product has just been updated
//   product      2*WIDTH-bit result, held until the next done
// -----------------------------------------------------------------------------
module seq_shift_add_mult #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t               state_r;
    logic [WIDTH:0]       mcand_r;     // |a|, one extra bit so -2^(WIDTH-1) fits
    logic [WIDTH:0]       mplier_r;    // |b|, shifted right once per iteration
    logic [2*WIDTH:0]     acc_r;       // partial product, top bit holds the carry
    logic [CNT_W-1:0]     count_r;
    logic                 neg_r;
    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   product_r;

    logic [WIDTH+1:0]     sum_s;
    logic [2*WIDTH:0]     acc_next_s;
    logic [2*WIDTH-1:0]   prod_s;

    // Magnitude of an operand; in signed mode a set MSB means negate.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
        logic [WIDTH:0] ext;
        ext = {is_signed & v[WIDTH-1], v};
        if (ext[WIDTH]) begin
            magnitude = ~ext + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            magnitude = ext;
        end
    endfunction

    // One shift-add step: conditional add into the upper half, then shift right.
    always_comb begin
        sum_s = {1'b0, acc_r[2*WIDTH:WIDTH]};
        if (mplier_r[0]) begin
            sum_s = {1'b0, acc_r[2*WIDTH:WIDTH]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_r[2*WIDTH:WIDTH]};
        end
        // Dropping acc_r[0] and appending the sum above it is the right shift.
        acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
    end

    // Apply the recorded sign to the unsigned accumulator.
    always_comb begin
        prod_s = acc_r[2*WIDTH-1:0];
        if (neg_r) begin
            prod_s = ~acc_r[2*WIDTH-1:0] + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            prod_s = acc_r[2*WIDTH-1:0];
        end
    end

    // Controller and datapath registers, including the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            mcand_r   <= {(WIDTH+1){1'b0}};
            mplier_r  <= {(WIDTH+1){1'b0}};
            acc_r     <= {(2*WIDTH+1){1'b0}};
            count_r   <= {CNT_W{1'b0}};
            neg_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r  <= magnitude(a_in, signed_mode);
                        mplier_r <= magnitude(b_in, signed_mode);
                        neg_r    <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        acc_r    <= {(2*WIDTH+1){1'b0}};
                        count_r  <= CNT_W'(WIDTH);
                        busy_r   <= 1'b1;
                        state_r  <= ST_CALC;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= {1'b0, mplier_r[WIDTH:1]};
                    count_r  <= count_r - CNT_W'(1);
                    if (count_r == CNT_W'(1)) begin
                        state_r <= ST_FINISH;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_FINISH: begin
                    product_r <= prod_s;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    // Illegal encoding: fall back to a clean idle state.
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    product_r <= {(2*WIDTH){1'b0}};
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule
